// File: rtl/ap_pkg.sv
// ap_pkg: AP instruction-format constants and instruction-cache state encoding.
package ap_pkg;

  localparam int unsigned OPCODE_WIDTH   = 4;
  localparam int unsigned CAM_ADDR_WIDTH = 8;
  localparam int unsigned OPERAND2_WIDTH = 2;
  localparam int unsigned MEM_ADDR_WIDTH = 16;
  localparam int unsigned AP_ISA_WIDTH   = OPCODE_WIDTH + CAM_ADDR_WIDTH +
                                           OPERAND2_WIDTH + MEM_ADDR_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP  = 4'h3;

  localparam logic [OPERAND2_WIDTH-1:0] OP2_REG = 2'd0;
  localparam logic [OPERAND2_WIDTH-1:0] OP2_IMM = 2'd1;
  localparam logic [OPERAND2_WIDTH-1:0] OP2_CAM = 2'd2;
  localparam logic [OPERAND2_WIDTH-1:0] OP2_MEM = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_UNCACHED,
    S_RESP
  } cache_state_t;

  // Saturating 16-bit increment for the debug event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ins_cache_dm_if.sv
// ins_cache_dm_if: DDR burst-read channel between the instruction cache and DDR.
interface ins_cache_dm_if #(
  parameter int unsigned ISA_WIDTH      = 30,
  parameter int unsigned DDR_ADDR_WIDTH = 28
);
  logic                      ISA_read_req;
  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr;
  logic [9:0]                isa_read_len;
  logic                      rd_burst_data_valid;
  logic [ISA_WIDTH-1:0]      instruction_to_cache;
  logic                      rd_burst_finish;

  modport master (
    output ISA_read_req, ISA_read_addr, isa_read_len,
    input  rd_burst_data_valid, instruction_to_cache, rd_burst_finish
  );

  modport slave (
    input  ISA_read_req, ISA_read_addr, isa_read_len,
    output rd_burst_data_valid, instruction_to_cache, rd_burst_finish
  );
endinterface

// File: rtl/ins_cache_ram.sv
// ins_cache_ram: simple dual-port synchronous RAM holding the cache line data.
module ins_cache_ram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned DW    = 30
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Refill write port and one-cycle-latency read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ins_cache_dm.sv
// ins_cache_dm: direct-mapped instruction cache with burst refill, uncached
// region (pc_addr MSB set), full flush and saturating hit/miss counters.
module ins_cache_dm
  import ap_pkg::*;
#(
  parameter int unsigned ISA_WIDTH      = AP_ISA_WIDTH,
  parameter int unsigned ADDR_WIDTH_MEM = 16,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned LINES          = 8,
  parameter int unsigned LINE_WORDS     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pc_req,
  input  logic [ADDR_WIDTH_MEM-1:0] pc_addr,
  input  logic                      flush,
  output logic                      ins_rdy,
  output logic [ISA_WIDTH-1:0]      instruction,
  output logic                      ins_valid,
  ins_cache_dm_if.master            ddr,
  output logic [15:0]               hit_cnt,
  output logic [15:0]               miss_cnt
);
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_WIDTH_MEM - 1 - OFF_W - IDX_W;
  localparam int unsigned RAM_AW = OFF_W + IDX_W;
  localparam int unsigned MSB    = ADDR_WIDTH_MEM - 1;

  cache_state_t state_q, state_d;

  logic [ADDR_WIDTH_MEM-1:0]   addr_q;
  logic [LINES-1:0]            valid_q;
  logic [LINES-1:0][TAG_W-1:0] tags_q;
  logic [OFF_W:0]              beat_cnt;
  logic                        flushed_q;
  logic                        fin_q;
  logic                        req_q;
  logic [DDR_ADDR_WIDTH-1:0]   rd_addr_q;
  logic [9:0]                  len_q;
  logic [ISA_WIDTH-1:0]        hold_q;
  logic [ISA_WIDTH-1:0]        instr_q;
  logic [ISA_WIDTH-1:0]        ram_rdata;
  logic [15:0]                 hit_q, miss_q;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             beat_ok;
  logic             ram_we;

  assign off = addr_q[OFF_W-1:0];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign tag = addr_q[MSB-1 -: TAG_W];

  // A flush in the lookup cycle forces a miss.
  assign hit     = valid_q[idx] && (tags_q[idx] == tag) && !flush;
  // Beats count only while a burst is outstanding; beats past the line are dropped.
  assign beat_ok = req_q && ddr.rd_burst_data_valid && !beat_cnt[OFF_W];
  assign ram_we  = (state_q == S_REFILL) && beat_ok;

  assign ddr.ISA_read_req  = req_q;
  assign ddr.ISA_read_addr = rd_addr_q;
  assign ddr.isa_read_len  = len_q;
  assign hit_cnt           = hit_q;
  assign miss_cnt          = miss_q;

  ins_cache_ram #(
    .DEPTH (LINES * LINE_WORDS),
    .AW    (RAM_AW),
    .DW    (ISA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({idx, beat_cnt[OFF_W-1:0]}),
    .wdata (ddr.instruction_to_cache),
    .raddr ({idx, off}),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and response outputs.
  always_comb begin
    state_d     = state_q;
    ins_rdy     = 1'b0;
    ins_valid   = 1'b0;
    instruction = instr_q;
    case (state_q)
      S_IDLE: begin
        ins_rdy = !rst;
        if (pc_req) state_d = pc_addr[MSB] ? S_UNCACHED : S_LOOKUP;
      end
      S_LOOKUP:   state_d = hit ? S_RESP : S_REFILL;
      S_REFILL,
      S_UNCACHED: if (fin_q) state_d = S_RESP;
      S_RESP: begin
        ins_valid   = 1'b1;
        instruction = addr_q[MSB] ? hold_q : ram_rdata;
        state_d     = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Request latch, DDR burst control, beat counting and response hold.
  // The response waits one extra cycle after finish (fin_q) so the last
  // refill beat is in the RAM before the requested word is read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      beat_cnt  <= '0;
      flushed_q <= 1'b0;
      fin_q     <= 1'b0;
      req_q     <= 1'b0;
      rd_addr_q <= '0;
      len_q     <= '0;
      hold_q    <= '0;
      instr_q   <= '0;
    end else begin
      fin_q <= req_q && ddr.rd_burst_finish;
      if (state_q == S_IDLE && pc_req) begin
        addr_q    <= pc_addr;
        beat_cnt  <= '0;
        flushed_q <= 1'b0;
        if (pc_addr[MSB]) begin
          req_q     <= 1'b1;
          rd_addr_q <= DDR_ADDR_WIDTH'(pc_addr) << 3;
          len_q     <= 10'd1;
        end
      end
      if (state_q == S_LOOKUP && !hit) begin
        req_q     <= 1'b1;
        rd_addr_q <= DDR_ADDR_WIDTH'({addr_q[MSB:OFF_W], {OFF_W{1'b0}}}) << 3;
        len_q     <= 10'(LINE_WORDS);
      end
      if (beat_ok) beat_cnt <= beat_cnt + (OFF_W+1)'(1);
      if (state_q == S_UNCACHED && beat_ok && beat_cnt == '0)
        hold_q <= ddr.instruction_to_cache;
      if (req_q && ddr.rd_burst_finish) req_q <= 1'b0;
      if (state_q == S_REFILL && flush) flushed_q <= 1'b1;
      if (state_q == S_RESP) instr_q <= instruction;
    end
  end

  // Tag/valid arrays; flush has priority over every other valid update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tags_q  <= '0;
    end else begin
      if (state_q == S_LOOKUP && !hit) valid_q[idx] <= 1'b0;
      if (state_q == S_REFILL && req_q && ddr.rd_burst_finish) begin
        tags_q[idx] <= tag;
        if (!flushed_q) valid_q[idx] <= 1'b1;
      end
      if (flush) valid_q <= '0;
    end
  end

  // Saturating hit/miss counters, updated in the lookup cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) hit_q  <= sat_inc16(hit_q);
      else     miss_q <= sat_inc16(miss_q);
    end
  end
endmodule

// File: tb/tb_ins_cache_dm.sv
// tb_ins_cache_dm: directed plus randomized fetches against a line-level
// reference model (valid/tag per line, static DDR contents).
module tb_ins_cache_dm;
  import ap_pkg::*;

  localparam int unsigned ISA_W = AP_ISA_WIDTH;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 28;
  localparam int unsigned LINES = 8;
  localparam int unsigned LW    = 16;
  localparam int unsigned OFF_W = 4;
  localparam int unsigned IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst, pc_req, flush;
  logic [AW-1:0]    pc_addr;
  logic             ins_rdy, ins_valid;
  logic [ISA_W-1:0] instruction;
  logic [15:0]      hit_cnt, miss_cnt;

  ins_cache_dm_if #(.ISA_WIDTH(ISA_W), .DDR_ADDR_WIDTH(DW)) ddr ();

  ins_cache_dm #(
    .ISA_WIDTH      (ISA_W),
    .ADDR_WIDTH_MEM (AW),
    .DDR_ADDR_WIDTH (DW),
    .LINES          (LINES),
    .LINE_WORDS     (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_req      (pc_req),
    .pc_addr     (pc_addr),
    .flush       (flush),
    .ins_rdy     (ins_rdy),
    .instruction (instruction),
    .ins_valid   (ins_valid),
    .ddr         (ddr),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  bit          mvalid [LINES];
  int unsigned mtag   [LINES];
  int unsigned mhit, mmiss;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // DDR contents: every word address maps to a distinct instruction.
  function automatic logic [ISA_W-1:0] ddr_word(input logic [AW-1:0] wa);
    logic [3:0] op;
    logic [1:0] op2;
    case (wa[1:0])
      2'd0:    op = OP_NOP;
      2'd1:    op = OP_LOAD;
      2'd2:    op = OP_STORE;
      default: op = OP_JUMP;
    endcase
    case (wa[3:2])
      2'd0:    op2 = OP2_REG;
      2'd1:    op2 = OP2_IMM;
      2'd2:    op2 = OP2_CAM;
      default: op2 = OP2_MEM;
    endcase
    return {op, wa[7:0] ^ wa[15:8], op2, wa ^ 16'h5A3C};
  endfunction

  task automatic clear_valids();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  task automatic model_reset();
    clear_valids();
    mhit  = 0;
    mmiss = 0;
  endtask

  function automatic logic [63:0] sat(input int unsigned v);
    return (v > 65535) ? 64'd65535 : 64'(v);
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rdy"},   64'(ins_rdy), 64'd0);
    check({pfx, "_valid"}, 64'(ins_valid), 64'd0);
    check({pfx, "_instr"}, 64'(instruction), 64'd0);
    check({pfx, "_req"},   64'(ddr.ISA_read_req), 64'd0);
    check({pfx, "_addr"},  64'(ddr.ISA_read_addr), 64'd0);
    check({pfx, "_len"},   64'(ddr.isa_read_len), 64'd0);
    check({pfx, "_hit"},   64'(hit_cnt), 64'd0);
    check({pfx, "_miss"},  64'(miss_cnt), 64'd0);
  endtask

  // Serve one burst: n real beats, optional junk beat past the end, random gaps,
  // optional flush on one beat, finish on the last beat or one cycle later.
  // Ends in the cycle after the finish cycle.
  task automatic serve(input logic [AW-1:0] base, input int unsigned n,
                       input bit do_flush, input bit junk, output bit flushed);
    int unsigned total, fl_at;
    bit fin_done;
    logic [DW-1:0] a0;
    logic [9:0] l0;
    total = n + (junk ? 1 : 0);
    fl_at = $urandom_range(total - 1, 0);
    a0 = ddr.ISA_read_addr;
    l0 = ddr.isa_read_len;
    flushed = 1'b0;
    fin_done = 1'b0;
    if (junk) begin
      pc_req  = 1'b1;  // busy: must be ignored
      pc_addr = ~base;
    end
    for (int unsigned k = 0; k < total; k++) begin
      repeat ($urandom_range(1, 0)) step();
      check("burst_req_held", 64'(ddr.ISA_read_req), 64'd1);
      check("burst_addr_stable", 64'({ddr.ISA_read_addr, ddr.isa_read_len}), 64'({a0, l0}));
      ddr.rd_burst_data_valid  = 1'b1;
      ddr.instruction_to_cache = (k < n) ? ddr_word(base + AW'(k)) : ~ddr_word(base);
      if (do_flush && k == fl_at) begin
        flush = 1'b1;
        flushed = 1'b1;
        clear_valids();
      end
      if (k == total - 1 && $urandom_range(1, 0) == 1) begin
        ddr.rd_burst_finish = 1'b1;
        fin_done = 1'b1;
      end
      step();
      ddr.rd_burst_data_valid = 1'b0;
      flush = 1'b0;
    end
    pc_req = 1'b0;
    if (!fin_done) begin
      ddr.rd_burst_finish = 1'b1;
      step();
    end
    ddr.rd_burst_finish = 1'b0;
  endtask

  task automatic respond(input logic [ISA_W-1:0] exp);
    check("fin_req_low", 64'(ddr.ISA_read_req), 64'd0);
    check("fin_no_valid", 64'(ins_valid), 64'd0);
    step();
    check("resp_valid", 64'(ins_valid), 64'd1);
    check("resp_data", 64'(instruction), 64'(exp));
  endtask

  // fm: 0 no flush, 1 flush in the cycle after accept, 2 flush during the burst.
  task automatic fetch(input logic [AW-1:0] a, input int unsigned fm, input bit junk);
    int unsigned idx, tg, n;
    bit hit, flushed;
    logic [AW-1:0] base;
    logic [ISA_W-1:0] exp;
    idx  = int'(a[OFF_W +: IDX_W]);
    tg   = int'(a[AW-2:OFF_W+IDX_W]);
    exp  = ddr_word(a);
    base = {a[AW-1:OFF_W], OFF_W'(0)};
    check("rdy", 64'(ins_rdy), 64'd1);
    pc_req = 1'b1;
    pc_addr = a;
    step();
    pc_req = 1'b0;
    if (fm == 1) begin
      flush = 1'b1;
      clear_valids();
    end
    hit = !a[AW-1] && mvalid[idx] && (mtag[idx] == tg);
    step();
    flush = 1'b0;
    if (a[AW-1]) begin
      n = 0;
      while (!ddr.ISA_read_req && n < 6) begin
        step();
        n++;
      end
      check("unc_req", 64'(ddr.ISA_read_req), 64'd1);
      if (!ddr.ISA_read_req) return;
      check("unc_addr", 64'(ddr.ISA_read_addr), 64'(a) * 8);
      check("unc_len", 64'(ddr.isa_read_len), 64'd1);
      serve(a, 1, fm == 2, junk, flushed);
      respond(exp);
    end else if (hit) begin
      mhit++;
      check("hit_valid", 64'(ins_valid), 64'd1);
      check("hit_no_req", 64'(ddr.ISA_read_req), 64'd0);
      check("hit_data", 64'(instruction), 64'(exp));
    end else begin
      mmiss++;
      mvalid[idx] = 1'b0;
      check("miss_req", 64'(ddr.ISA_read_req), 64'd1);
      check("miss_addr", 64'(ddr.ISA_read_addr), 64'(base) * 8);
      check("miss_len", 64'(ddr.isa_read_len), 64'(LW));
      serve(base, LW, fm == 2, junk, flushed);
      mtag[idx]   = tg;
      mvalid[idx] = !flushed;
      respond(exp);
    end
    step();
    check("idle_no_valid", 64'(ins_valid), 64'd0);
    check("hold_instr", 64'(instruction), 64'(exp));
    check("hit_cnt", 64'(hit_cnt), sat(mhit));
    check("miss_cnt", 64'(miss_cnt), sat(mmiss));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pc_req = 1'b0;
    pc_addr = '0;
    flush = 1'b0;
    ddr.rd_burst_data_valid  = 1'b0;
    ddr.instruction_to_cache = '0;
    ddr.rd_burst_finish      = 1'b0;
    model_reset();
    repeat (2) step();
    check_reset_outputs("rst");
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 64'(ins_rdy), 64'd1);
    step();

    fetch(16'h0010, 0, 1'b1);                        // cold miss, 0x80/16
    for (int unsigned w = 16'h11; w <= 16'h1F; w++)  // rest of the line hits
      fetch(AW'(w), 0, 1'b0);
    fetch(16'h0090, 0, 1'b0);                        // same index, refill at 0x480
    fetch(16'h0010, 0, 1'b0);                        // evicted: misses again
    fetch(16'h8003, 0, 1'b1);                        // uncached, 0x40018/1
    fetch(16'h0011, 0, 1'b0);                        // line untouched by uncached
    fetch(16'h0020, 2, 1'b0);                        // flush during refill
    fetch(16'h0020, 0, 1'b0);                        // line ended invalid
    fetch(16'h0021, 1, 1'b0);                        // flush beats a lookup hit

    // Reset in the middle of a refill burst; late beats must be ignored.
    pc_req = 1'b1;
    pc_addr = 16'h0030;
    step();
    pc_req = 1'b0;
    step();
    check("rb_req", 64'(ddr.ISA_read_req), 64'd1);
    for (int unsigned k = 0; k < 3; k++) begin
      ddr.rd_burst_data_valid  = 1'b1;
      ddr.instruction_to_cache = ddr_word(AW'(16'h0030 + k));
      step();
    end
    ddr.rd_burst_data_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rb_rst");
    step();
    step();
    rst = 1'b0;
    model_reset();
    for (int unsigned k = 0; k < 3; k++) begin
      ddr.rd_burst_data_valid  = 1'b1;
      ddr.instruction_to_cache = ~ddr_word(AW'(16'h0033 + k));
      ddr.rd_burst_finish      = (k == 2);
      step();
      check("late_no_req", 64'(ddr.ISA_read_req), 64'd0);
      check("late_no_valid", 64'(ins_valid), 64'd0);
    end
    ddr.rd_burst_data_valid = 1'b0;
    ddr.rd_burst_finish     = 1'b0;
    step();
    fetch(16'h0010, 0, 1'b0);                        // previously cached line misses
    fetch(16'h0030, 0, 1'b0);

    // Randomized fetches over a small address pool so lines collide and hit.
    for (int unsigned i = 0; i < 150; i++) begin
      logic [AW-1:0] a;
      int unsigned r;
      a = AW'((($urandom_range(2, 0)) << (OFF_W + IDX_W)) |
              (($urandom_range(LINES - 1, 0)) << OFF_W) |
              $urandom_range(LW - 1, 0));
      if ($urandom_range(7, 0) == 0) a[AW-1] = 1'b1;
      r = $urandom_range(7, 0);
      fetch(a, (r == 0) ? 1 : (r == 1) ? 2 : 0, 1'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ins_cache_dm.md
# ins_cache_dm

Parametrised direct-mapped instruction cache between the AP program counter and the DDR interface, replacing the single-block preload cache. It holds LINES lines of LINE_WORDS instructions, refills one line per miss by DDR burst, serves an uncached region for the interrupt service space, and supports a full flush. Hit/miss counters feed the debug path.

## Interface
- ISA_WIDTH, 30: instruction width (OPCODE 4 + CAM addr 8 + operand2 2 + mem addr 16)
- ADDR_WIDTH_MEM, 16: instruction word-address width
- DDR_ADDR_WIDTH, 28: DDR byte-address width
- LINES, 8: cache lines, power of two, ≥2
- LINE_WORDS, 16: words per line, power of two, 2..512
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pc_req  in  1  fetch request, sampled when ins_rdy=1
- pc_addr  in  ADDR_WIDTH_MEM  instruction word address
- flush  in  1  invalidate all lines (one-cycle pulse)
- ins_rdy  out  1  cache can accept a request
- instruction  out  ISA_WIDTH  fetched instruction, valid with ins_valid
- ins_valid  out  1  one-cycle response strobe
- ISA_read_req  out  1  DDR burst read request
- ISA_read_addr  out  DDR_ADDR_WIDTH  burst start byte address
- isa_read_len  out  10  burst length in words
- rd_burst_data_valid  in  1  DDR data beat valid
- instruction_to_cache  in  ISA_WIDTH  DDR data beat
- rd_burst_finish  in  1  burst complete pulse
- hit_cnt, miss_cnt  out  16 each  saturating event counters

## Operation
- Address split: offset = low log2(LINE_WORDS) bits, index = next log2(LINES) bits, tag = remaining bits below MSB. pc_addr MSB=1 is the uncached region.
- States: IDLE, LOOKUP, REFILL, UNCACHED, RESP.
- IDLE: ins_rdy=1; pc_req latches pc_addr -> LOOKUP (cached) or UNCACHED (MSB=1).
- LOOKUP: compare tag/valid of indexed line. Hit -> RESP, hit_cnt+1. Miss -> REFILL, miss_cnt+1, line valid bit cleared.
- REFILL: ISA_read_addr = zero-extended line-aligned word address ×8; isa_read_len = LINE_WORDS. Beat k (k-th rd_burst_data_valid) written to word k of line; beats beyond LINE_WORDS dropped. On rd_burst_finish: tag written, valid set (unless flushed during refill), -> RESP reading requested word.
- UNCACHED: ISA_read_addr = pc_addr×8 (MSB included), isa_read_len=1; first beat captured into a holding register, no allocation; on rd_burst_finish -> RESP.
- RESP: ins_valid=1, instruction driven, -> IDLE.
- flush: clears all valid bits same cycle; accepted in any state; during REFILL the line in flight ends invalid but the pending response still completes with fetched data.
- Counters saturate at 16'hFFFF; not cleared by flush.
- pc_req while ins_rdy=0 is ignored (no queuing).

## Timing
- Reset: ins_rdy=0 during reset, 1 first cycle after; instruction=0, ins_valid=0, ISA_read_req=0, ISA_read_addr=0, isa_read_len=0, counters=0, all valid bits 0, state IDLE.
- Hit latency: request accepted cycle N, ins_valid at N+2.
- Miss: ISA_read_req rises N+2, held high through rd_burst_finish cycle, low next cycle; ins_valid one cycle after the finish cycle is registered (finish+2).
- ISA_read_addr/isa_read_len stable whenever ISA_read_req=1.
- instruction holds last value after ins_valid drops.
- Reset mid-refill: burst abandoned, ISA_read_req low asynchronously, all lines invalid; late DDR beats ignored.
- Simultaneous flush and LOOKUP hit: flush wins, treated as miss.

## Structure
- Shared package ap_pkg: opcode and operand-2 constants, ISA_WIDTH derivation, cache state encoding.
- Sub-module ins_cache_ram: simple dual-port synchronous RAM, LINES×LINE_WORDS × ISA_WIDTH, one write port (refill), one read port (1-cycle latency). Tag/valid arrays stay in registers in the top.

## Test plan
- Cold fetch 0x0010 (LINE_WORDS=16) -> ISA_read_addr=0x80, len=16, ins_valid with beat 0, miss_cnt=1.
- Then fetch 0x0011..0x001F -> ins_valid at N+2 each, no ISA_read_req, hit_cnt=15.
- Fetch 0x0090 (same index, LINES=8) -> refill at 0x480; refetch 0x0010 -> miss again.
- Fetch 0x8003 -> len=1, addr=0x40018, line arrays unchanged, no counter change.
- flush during refill of 0x0020 -> response delivered, refetch 0x0020 misses.
- rst asserted mid-burst -> all outputs reset values, next fetch of previous line misses.
